// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam int          INST_W        = 32;

    // FAULT is only reachable when the alignment checker is built in
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        FLUSH = 3'd3,
        FAULT = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch sequencer and imem.
interface fetch_ctrl_if
    import fetch_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);

    logic              imem_req_o;
    logic [XLEN-1:0]   imem_addr_o;
    logic              imem_gnt_i;
    logic              imem_rvalid_i;
    logic [INST_W-1:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );

endinterface

// File: rtl/fetch_ctrl_out_reg.sv
// One-entry holding register that presents a fetched instruction to decode.
// kill beats capture, capture beats consume.
module fetch_ctrl_out_reg
    import fetch_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              consume,
    input  logic              kill,
    input  logic [INST_W-1:0] cap_inst,
    input  logic [XLEN-1:0]   cap_pc,
    output logic              valid,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   pc
);

    // Hold, load, or drop the single buffered instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            inst  <= '0;
            pc    <= '0;
        end else if (kill) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            inst  <= cap_inst;
            pc    <= cap_pc;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one outstanding imem request
// at a time and hands responses to decode through a one-entry output register.
// Optional macro FETCH_CTRL_ALIGN_CHK_EN adds misaligned-redirect detection
// (fault_o port and FAULT state); without it the low two target bits are dropped.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_i,
    input  logic [XLEN-1:0]   redirect_pc_i,
    input  logic              stall_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [XLEN-1:0]   inst_pc_o,
`ifdef FETCH_CTRL_ALIGN_CHK_EN
    output logic              fault_o,
`endif
    fetch_ctrl_if.master      imem
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] target;
    logic            can_issue;
    logic            req;
    logic            consume;
    logic            capture;
    logic            kill;

`ifdef FETCH_CTRL_ALIGN_CHK_EN
    logic            fault_q;
    logic            fault_d;
    logic            misaligned;

    assign target     = redirect_pc_i;
    assign misaligned = |redirect_pc_i[1:0];
    assign fault_o    = fault_q;
`else
    assign target     = redirect_pc_i & ~XLEN'(3);
`endif

    // A new request may only go out if the output slot is free by the next edge
    assign can_issue = ~inst_valid_o | ~stall_i;
    assign consume   = inst_valid_o & ~stall_i;
    assign req       = (state_q == REQ) & can_issue;

    assign imem.imem_req_o  = req;
    assign imem.imem_addr_o = pc_q;

    // Next-state, next-PC and output-register control; redirects override all
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        capture = 1'b0;
        kill    = 1'b0;
`ifdef FETCH_CTRL_ALIGN_CHK_EN
        fault_d = fault_q;
`endif
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (req && imem.imem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_rvalid_i) begin
                    capture = 1'b1;
                    pc_d    = pc_q + XLEN'(4);
                    state_d = REQ;
                end
            end
            FLUSH: begin
                if (imem.imem_rvalid_i) begin
                    state_d = REQ;
                end
            end
`ifdef FETCH_CTRL_ALIGN_CHK_EN
            FAULT: state_d = FAULT;
`endif
            default: state_d = IDLE;
        endcase

        if (redirect_i) begin
            kill    = 1'b1;
            capture = 1'b0;
            pc_d    = target;
            case (state_q)
                WAIT:    state_d = imem.imem_rvalid_i ? REQ : FLUSH;
                REQ:     state_d = (req && imem.imem_gnt_i) ? FLUSH : REQ;
                FLUSH:   state_d = imem.imem_rvalid_i ? REQ : FLUSH;
                default: state_d = REQ;
            endcase
`ifdef FETCH_CTRL_ALIGN_CHK_EN
            if (misaligned) begin
                state_d = FAULT;
                fault_d = 1'b1;
            end else begin
                fault_d = 1'b0;
            end
`endif
        end
    end

    // State and PC registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_VEC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef FETCH_CTRL_ALIGN_CHK_EN
    // Sticky misalignment flag, cleared by reset or an aligned redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`endif

    fetch_ctrl_out_reg #(
        .XLEN (XLEN)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .capture  (capture),
        .consume  (consume),
        .kill     (kill),
        .cap_inst (imem.imem_rdata_i),
        .cap_pc   (pc_q),
        .valid    (inst_valid_o),
        .inst     (inst_o),
        .pc       (inst_pc_o)
    );

endmodule
